uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_edge_bit_counter.sv | 29 ++
 rtl/uart_rx_fsm.sv | 131 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter for the UART receiver.
module uart_rx_edge_bit_counter #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cnt_en,
  input  logic                      last_edge,
  input  logic                      bit_inc,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt
);

  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

  // Edge count holds at zero while idle so a detect cycle always starts a frame at edge 0.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (!cnt_en || last_edge) edge_cnt <= '0;
      else                      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
      if (bit_inc) bit_cnt <= (bit_cnt == BIT_LAST) ? 4'd0 : bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: frame sequencing, check strobes and data_valid generation.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt
);

  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

  rx_state_t state, state_nxt;
  logic      par_en_q, frm_err, dv_q;
  logic      last_edge, bit_last, detect;
  logic      cnt_en, bit_inc;
  logic      samp_c, deser_c, strt_c, par_c, stp_c;

  assign last_edge = (edge_cnt == Prescale - PRESCALE_WIDTH'(1));
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign detect    = (state == IDLE) && !RX_IN;

  uart_rx_edge_bit_counter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .cnt_en    (cnt_en),
    .last_edge (last_edge),
    .bit_inc   (bit_inc),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt)
  );

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    bit_inc   = 1'b0;
    samp_c    = 1'b0;
    deser_c   = 1'b0;
    strt_c    = 1'b0;
    par_c     = 1'b0;
    stp_c     = 1'b0;
    case (state)
      IDLE: begin
        if (detect) begin
          cnt_en    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        cnt_en = 1'b1;
        samp_c = 1'b1;
        if (last_edge) begin
          strt_c    = 1'b1;
          state_nxt = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_en = 1'b1;
        samp_c = 1'b1;
        if (last_edge) begin
          deser_c = 1'b1;
          bit_inc = 1'b1;
          if (bit_last) state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        cnt_en = 1'b1;
        samp_c = 1'b1;
        if (last_edge) begin
          par_c     = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        samp_c = 1'b1;
        if (last_edge) begin
          stp_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Parity mode is frozen at the detect cycle; a parity failure poisons only the current frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      par_en_q <= 1'b0;
      frm_err  <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      dv_q  <= stp_c && !stp_err && !frm_err;
      if (detect) begin
        par_en_q <= PAR_EN;
        frm_err  <= 1'b0;
      end else if (par_c && par_err) begin
        frm_err <= 1'b1;
      end
    end
  end

  // Outputs are forced quiet during the reset cycle even though the state register updates only at the edge.
  assign dat_samp_en = samp_c  & RST;
  assign deser_en    = deser_c & RST;
  assign strt_chk_en = strt_c  & RST;
  assign par_chk_en  = par_c   & RST;
  assign stp_chk_en  = stp_c   & RST;
  assign data_valid  = dv_q    & RST;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frame-timing model plus directed scenarios.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int HN = 4096;
  localparam int P_SMALL = 2 * uart_pkg::MIN_PRESCALE;

  logic          CLK, RST, RX_IN, PAR_EN;
  logic [PW-1:0] Prescale;
  logic          strt_glitch, par_err, stp_err;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Frame-level model: a frame detected at cycle t0 occupies (DW+2+pe) bit periods;
  // the line is busy from t0+1 until idle_from, data_valid lands at dv_cycle.
  int  m_t0 = -1000;
  int  m_idle_from = 0;
  int  m_p = 8;
  bit  m_pe = 0;
  bit  m_ferr = 0;
  int  m_dv_cycle = -1;

  always @(negedge CLK) begin
    int  k, seg, e_ec, e_bc;
    bit  act, lst, e_samp, e_strt, e_deser, e_par, e_stp, e_dv;
    act = (cyc < m_idle_from) && (cyc > m_t0);
    e_samp = 0; e_strt = 0; e_deser = 0; e_par = 0; e_stp = 0; e_ec = 0; e_bc = 0;
    if (act) begin
      k       = cyc - m_t0;
      seg     = k / m_p;
      e_ec    = k % m_p;
      lst     = (e_ec == m_p - 1);
      e_samp  = 1;
      e_strt  = lst && (seg == 0);
      e_deser = lst && (seg >= 1) && (seg <= DW);
      e_par   = lst && m_pe && (seg == DW + 1);
      e_stp   = lst && (seg == DW + 1 + int'(m_pe));
      e_bc    = (seg >= 1 && seg <= DW) ? seg - 1 : 0;
    end
    e_dv = (cyc == m_dv_cycle);
    if (!RST) begin
      e_samp = 0; e_strt = 0; e_deser = 0; e_par = 0; e_stp = 0; e_dv = 0;
    end
    check("dat_samp_en", int'(dat_samp_en), int'(e_samp));
    check("deser_en",    int'(deser_en),    int'(e_deser));
    check("strt_chk_en", int'(strt_chk_en), int'(e_strt));
    check("par_chk_en",  int'(par_chk_en),  int'(e_par));
    check("stp_chk_en",  int'(stp_chk_en),  int'(e_stp));
    check("data_valid",  int'(data_valid),  int'(e_dv));
    if (RST) begin
      check("edge_cnt", int'(edge_cnt), e_ec);
      check("bit_cnt",  int'(bit_cnt),  e_bc);
      if (e_strt && strt_glitch) m_idle_from = m_t0 + m_p;
      if (e_par && par_err) m_ferr = 1;
      if (e_stp && !stp_err && !m_ferr) m_dv_cycle = cyc + 1;
      if (cyc >= m_idle_from && !RX_IN) begin
        m_t0        = cyc;
        m_p         = int'(Prescale);
        m_pe        = PAR_EN;
        m_ferr      = 0;
        m_idle_from = cyc + (DW + 2 + int'(m_pe)) * m_p;
      end
    end else begin
      m_idle_from = cyc + 1;
      m_dv_cycle  = -1;
      m_ferr      = 0;
    end
  end

  // Event log used by the hand-computed scenario expectations.
  logic          samp_h [0:HN-1];
  logic [PW-1:0] ec_h   [0:HN-1];
  logic [3:0]    bc_h   [0:HN-1];
  int obs_strt, obs_par, obs_par_cnt, obs_stp, obs_deser, obs_dv, obs_dv_last, obs_dv_cnt;

  task automatic clear_obs();
    obs_strt = -1; obs_par = -1; obs_par_cnt = 0; obs_stp = -1;
    obs_deser = 0; obs_dv = -1; obs_dv_last = -1; obs_dv_cnt = 0;
  endtask

  always @(negedge CLK) begin
    if (cyc < HN) begin
      samp_h[cyc] = dat_samp_en;
      ec_h[cyc]   = edge_cnt;
      bc_h[cyc]   = bit_cnt;
    end
    if (strt_chk_en && obs_strt < 0) obs_strt = cyc;
    if (par_chk_en) begin
      obs_par_cnt++;
      if (obs_par < 0) obs_par = cyc;
    end
    if (stp_chk_en && obs_stp < 0) obs_stp = cyc;
    if (deser_en) obs_deser++;
    if (data_valid) begin
      obs_dv_cnt++;
      if (obs_dv < 0) obs_dv = cyc;
      obs_dv_last = cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      RX_IN = 1'b1;
      RST   = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                            input int par_toggle, input int rst_at, output int t0);
    logic [11:0] bits;
    int          nb, off;
    nb   = DW + 2 + int'(pe);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    if (pe) bits[DW+1] = ^d;
    t0       = -1;
    Prescale = PW'(p);
    PAR_EN   = pe;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < p; e++) begin
        tick();
        off = b * p + e;
        if (off == 0) t0 = cyc;
        RX_IN = bits[b];
        RST   = (off == rst_at) ? 1'b0 : 1'b1;
        if (rst_at >= 0 && off > rst_at) RX_IN = 1'b1;
        if (off == par_toggle) PAR_EN = !pe;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int t, t2;
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = PW'(P_SMALL);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    clear_obs();
    repeat (3) tick();
    @(negedge CLK);
    check("rst_edge_cnt", int'(edge_cnt), 0);
    check("rst_bit_cnt",  int'(bit_cnt), 0);
    check("rst_samp",     int'(dat_samp_en), 0);
    check("rst_dv",       int'(data_valid), 0);
    idle(5);

    // Plain 8N1 frame
    clear_obs();
    send_frame(8'hA5, P_SMALL, 1'b0, -1, -1, t);
    idle(10);
    check("s1_deser_cnt", obs_deser, 8);
    check("s1_strt_t",    obs_strt - t, 7);
    check("s1_stp_t",     obs_stp - t, 79);
    check("s1_dv_t",      obs_dv - t, 80);
    check("s1_dv_cnt",    obs_dv_cnt, 1);
    check("s1_bc_mid",    int'(bc_h[t+45]), 4);

    // Parity frame with parity error
    clear_obs();
    par_err = 1'b1;
    send_frame(8'h3C, 16, 1'b1, -1, -1, t);
    idle(10);
    par_err = 1'b0;
    check("s2_par_t",    obs_par - t, 159);
    check("s2_stp_t",    obs_stp - t, 175);
    check("s2_dv_cnt",   obs_dv_cnt, 0);
    check("s2_busy_175", int'(samp_h[t+175]), 1);
    check("s2_idle_176", int'(samp_h[t+176]), 0);

    // Start-bit glitch
    clear_obs();
    strt_glitch = 1'b1;
    Prescale = PW'(P_SMALL);
    PAR_EN = 1'b0;
    tick();
    t = cyc;
    RX_IN = 1'b0;
    repeat (3) begin tick(); RX_IN = 1'b0; end
    idle(30);
    strt_glitch = 1'b0;
    check("s3_strt_t",    obs_strt - t, 7);
    check("s3_busy_7",    int'(samp_h[t+7]), 1);
    check("s3_idle_8",    int'(samp_h[t+8]), 0);
    check("s3_deser_cnt", obs_deser, 0);
    check("s3_dv_cnt",    obs_dv_cnt, 0);

    // Back-to-back frames
    clear_obs();
    send_frame(8'hA5, P_SMALL, 1'b0, -1, -1, t);
    idle(1);
    send_frame(8'h5A, P_SMALL, 1'b0, -1, -1, t2);
    idle(10);
    check("s4_t2_start",  t2 - t, 81);
    check("s4_dv1_t",     obs_dv - t, 80);
    check("s4_dv2_t",     obs_dv_last - t, 161);
    check("s4_dv_cnt",    obs_dv_cnt, 2);
    check("s4_deser_cnt", obs_deser, 16);

    // Mid-frame reset
    clear_obs();
    send_frame(8'hA5, P_SMALL, 1'b0, -1, 30, t);
    idle(100);
    check("s5_ec_29",   int'(ec_h[t+29]), 5);
    check("s5_bc_29",   int'(bc_h[t+29]), 2);
    check("s5_samp_31", int'(samp_h[t+31]), 0);
    check("s5_ec_31",   int'(ec_h[t+31]), 0);
    check("s5_bc_31",   int'(bc_h[t+31]), 0);
    check("s5_dv_cnt",  obs_dv_cnt, 0);

    // Line break
    clear_obs();
    stp_err = 1'b1;
    Prescale = PW'(P_SMALL);
    PAR_EN = 1'b0;
    tick();
    t = cyc;
    RX_IN = 1'b0;
    repeat (99) begin tick(); RX_IN = 1'b0; end
    idle(100);
    stp_err = 1'b0;
    check("s6_stp_t",   obs_stp - t, 79);
    check("s6_idle_80", int'(samp_h[t+80]), 0);
    check("s6_busy_81", int'(samp_h[t+81]), 1);
    check("s6_ec_81",   int'(ec_h[t+81]), 1);
    check("s6_dv_cnt",  obs_dv_cnt, 0);

    // PAR_EN change mid-frame takes effect on the next frame only
    clear_obs();
    send_frame(8'hA5, P_SMALL, 1'b0, 20, -1, t);
    idle(5);
    send_frame(8'hC3, P_SMALL, 1'b1, -1, -1, t2);
    idle(10);
    check("s7_dv1_t",    obs_dv - t, 80);
    check("s7_par_cnt",  obs_par_cnt, 1);
    check("s7_par_t",    obs_par - t2, 79);
    check("s7_dv2_t",    obs_dv_last - t2, 88);
    check("s7_dv_cnt",   obs_dv_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
